hazard_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the stall (hold) and flush (bubble) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory accesses through a req/ready handshake with timeout. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Purpose : stall/flush controller for the 5-stage pipeline (load-use, taken branch, data-memory wait).
// Latency : stall_*/flush_* are combinational from inputs and FSM state; counters/flags update on clk.
// Backpressure: a pending data-memory access freezes F/D/E/M until mem_ready_M or MEM_TIMEOUT expires.
//
// Ports:
//   clk, rst_n                   clock and async active-low reset
//   rs1_D, rs2_D                 decode-stage source registers
//   rd_E, ctrl_register_file_WE_E, ctrl_result_E, branch_taken_E   execute-stage info
//   mem_req_M, mem_ready_M       memory-stage data access handshake
//   stall_F/D/E/M                hold PC and pipeline registers
//   flush_D/E/W                  insert bubble into IF/ID, ID/EX, MEM/WB
//   mem_err                      sticky data-memory timeout flag
//   stall_count                  saturating count of cycles with stall_F=1
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rd_E,
   input  logic             ctrl_register_file_WE_E,
   input  logic             ctrl_result_E,
   input  logic             branch_taken_E,
   input  logic             mem_req_M,
   input  logic             mem_ready_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             flush_W,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} fsm_t;

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   fsm_t       fsm;
   logic [7:0] wait_cnt;
   logic       mw;
   logic       lu;

   // Memory wait: in MEM_WAIT the stall drops on the timeout cycle even without ready.
   always_comb begin
      mw = 1'b0;
      if (fsm == RUN) mw = mem_req_M & ~mem_ready_M;
      else            mw = ~mem_ready_M & (wait_cnt != TMO);
   end

   assign lu = ctrl_result_E & ctrl_register_file_WE_E & (rd_E != 5'd0) &
               ((rd_E == rs1_D) | (rd_E == rs2_D));

   // Priority: memory wait > taken branch > load-use. While in reset every
   // stage is flushed and nothing is held.
   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_W = 1'b0;
      if (!rst_n) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
         flush_W = 1'b1;
      end else if (mw) begin
         // Execute is frozen, so branch/load-use are re-evaluated after release.
         stall_F = 1'b1;
         stall_D = 1'b1;
         stall_E = 1'b1;
         stall_M = 1'b1;
         flush_W = 1'b1;
      end else if (branch_taken_E) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else if (lu) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         flush_E = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm         <= RUN;
         wait_cnt    <= 8'd0;
         mem_err     <= 1'b0;
         stall_count <= '0;
      end else begin
         case (fsm)
            RUN: begin
               if (mem_req_M && !mem_ready_M) begin
                  fsm      <= MEM_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (mem_ready_M) begin
                  // Ready on the timeout cycle still counts as success.
                  fsm      <= RUN;
                  wait_cnt <= 8'd0;
               end else if (wait_cnt != TMO) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end else begin
                  // Access abandoned; read data is taken as-is.
                  fsm      <= RUN;
                  wait_cnt <= 8'd0;
                  mem_err  <= 1'b1;
               end
            end
            default: begin
               fsm      <= RUN;
               wait_cnt <= 8'd0;
            end
         endcase

         if (stall_F && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs1_D, rs2_D, rd_E;
   logic       we_E, res_E, br_E, req_M, rdy_M;

   logic sF, sD, sE, sM, fD, fE, fW, err;
   logic sF4, sD4, sE4, sM4, fD4, fE4, fW4, err4;
   logic [31:0] cnt;
   logic [3:0]  cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   // {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_W}
   localparam logic [6:0] C_NONE = 7'b0000_000;
   localparam logic [6:0] C_RST  = 7'b0000_111;
   localparam logic [6:0] C_LU   = 7'b1100_010;
   localparam logic [6:0] C_BR   = 7'b0000_110;
   localparam logic [6:0] C_MW   = 7'b1111_001;

   logic [6:0] ctl, ctl4;
   assign ctl  = {sF, sD, sE, sM, fD, fE, fW};
   assign ctl4 = {sF4, sD4, sE4, sM4, fD4, fE4, fW4};

   hazard_stall_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_E(rd_E),
      .ctrl_register_file_WE_E(we_E), .ctrl_result_E(res_E), .branch_taken_E(br_E),
      .mem_req_M(req_M), .mem_ready_M(rdy_M),
      .stall_F(sF), .stall_D(sD), .stall_E(sE), .stall_M(sM),
      .flush_D(fD), .flush_E(fE), .flush_W(fW), .mem_err(err), .stall_count(cnt)
   );

   hazard_stall_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_E(rd_E),
      .ctrl_register_file_WE_E(we_E), .ctrl_result_E(res_E), .branch_taken_E(br_E),
      .mem_req_M(req_M), .mem_ready_M(rdy_M),
      .stall_F(sF4), .stall_D(sD4), .stall_E(sE4), .stall_M(sM4),
      .flush_D(fD4), .flush_E(fE4), .flush_W(fW4), .mem_err(err4), .stall_count(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1_D = 5'd0; rs2_D = 5'd0; rd_E = 5'd0;
      we_E = 1'b0; res_E = 1'b0; br_E = 1'b0;
      req_M = 1'b0; rdy_M = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic we, input logic res);
      rd_E = rd; rs1_D = r1; rs2_D = r2; we_E = we; res_E = res;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #3;
      chk("rst_ctl", 32'(ctl), 32'(C_RST));
      chk("rst_ctl4", 32'(ctl4), 32'(C_RST));
      chk("rst_cnt", cnt, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ctl", 32'(ctl), 32'(C_NONE));
      tick();
      chk("post_rst_cnt", cnt, 32'd0);
      chk("post_rst_err", 32'(err), 32'd0);

      // Load-use on rs2
      set_lu(5'd5, 5'd0, 5'd5, 1'b1, 1'b1);
      @(negedge clk);
      chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
      tick();
      idle();
      chk("lu_cnt", cnt, 32'd1);
      @(negedge clk);
      chk("lu_gone_ctl", 32'(ctl), 32'(C_NONE));
      tick();

      // rd_E = x0 never hazards
      set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      @(negedge clk);
      chk("lu_x0_ctl", 32'(ctl), 32'(C_NONE));
      tick();
      // Not a load
      set_lu(5'd7, 5'd7, 5'd3, 1'b1, 1'b0);
      @(negedge clk);
      chk("lu_noload_ctl", 32'(ctl), 32'(C_NONE));
      tick();
      // Load with no write-enable
      set_lu(5'd7, 5'd7, 5'd3, 1'b0, 1'b1);
      @(negedge clk);
      chk("lu_nowe_ctl", 32'(ctl), 32'(C_NONE));
      tick();
      // Load-use on rs1, two consecutive cycles
      set_lu(5'd31, 5'd31, 5'd2, 1'b1, 1'b1);
      @(negedge clk);
      chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
      tick();
      @(negedge clk);
      chk("lu_rs1_ctl2", 32'(ctl), 32'(C_LU));
      tick();
      chk("lu_rs1_cnt", cnt, 32'd3);

      // Branch beats load-use
      br_E = 1'b1;
      @(negedge clk);
      chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
      tick();
      idle();
      chk("br_cnt", cnt, 32'd3);

      // Memory wait: ready low 3 cycles, then high
      req_M = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mw3_ctl%0d", i), 32'(ctl), 32'(C_MW));
         tick();
      end
      rdy_M = 1'b1;
      @(negedge clk);
      chk("mw3_rel_ctl", 32'(ctl), 32'(C_NONE));
      tick();
      idle();
      chk("mw3_cnt", cnt, 32'd6);
      chk("mw3_err", 32'(err), 32'd0);
      @(negedge clk);
      chk("mw3_idle_ctl", 32'(ctl), 32'(C_NONE));
      tick();

      // Single-cycle access: req and ready together
      req_M = 1'b1; rdy_M = 1'b1;
      @(negedge clk);
      chk("mw1_ctl", 32'(ctl), 32'(C_NONE));
      tick();
      idle();

      // Wait with branch and load-use present: both ignored until release
      req_M = 1'b1; br_E = 1'b1;
      set_lu(5'd4, 5'd4, 5'd0, 1'b1, 1'b1);
      @(negedge clk);
      chk("mwbr_ctl0", 32'(ctl), 32'(C_MW));
      tick();
      @(negedge clk);
      chk("mwbr_ctl1", 32'(ctl), 32'(C_MW));
      tick();
      rdy_M = 1'b1;
      @(negedge clk);
      chk("mwbr_rel_ctl", 32'(ctl), 32'(C_BR));
      tick();
      idle();
      chk("mwbr_cnt", cnt, 32'd8);
      chk("mwbr_cnt4", 32'(cnt4), 32'd8);

      // Timeout: 15 stalled cycles, released on the 16th
      req_M = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk($sformatf("tmo_ctl%0d", i), 32'(ctl), 32'(C_MW));
         tick();
      end
      @(negedge clk);
      chk("tmo_rel_ctl", 32'(ctl), 32'(C_NONE));
      chk("tmo_err_before", 32'(err), 32'd0);
      tick();
      idle();
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_cnt", cnt, 32'd23);
      chk("tmo_cnt4_sat", 32'(cnt4), 32'd15);

      // mem_err sticky across later traffic; 4-bit counter stays saturated
      set_lu(5'd9, 5'd1, 5'd9, 1'b1, 1'b1);
      @(negedge clk);
      chk("sticky_ctl", 32'(ctl), 32'(C_LU));
      tick();
      idle();
      req_M = 1'b1; rdy_M = 1'b1;
      tick();
      idle();
      chk("sticky_err", 32'(err), 32'd1);
      chk("sticky_cnt", cnt, 32'd24);
      chk("sticky_cnt4", 32'(cnt4), 32'd15);

      // Ready arriving exactly on the timeout cycle is success
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      req_M = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      rdy_M = 1'b1;
      @(negedge clk);
      chk("tmo_rdy_ctl", 32'(ctl), 32'(C_NONE));
      tick();
      idle();
      chk("tmo_rdy_err", 32'(err), 32'd0);
      chk("tmo_rdy_cnt", cnt, 32'd15);

      // Reset in the middle of MEM_WAIT
      req_M = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_ctl", 32'(ctl), 32'(C_RST));
      chk("midrst_cnt", cnt, 32'd0);
      req_M = 1'b0; rdy_M = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      // Ready low with no request would stall if the FSM were still waiting
      chk("midrst_run_ctl", 32'(ctl), 32'(C_NONE));
      tick();
      chk("midrst_err", 32'(err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
